// File: rtl/shift_reg_pkg.sv
// Shared definitions for the universal shift register: op encodings, FSM states
// and the predicate that tells which ops may run as a multi-step burst.
package shift_reg_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_CLR  = 3'b111
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Only the shift/rotate ops (SHL..ASR) make sense repeated in a burst.
  function automatic logic is_shift_class(input logic [2:0] m);
    return (m >= MODE_SHL) && (m <= MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_reg_step.sv
// Combinational next-value unit: applies one op to the current register value.
// Shared by the single-cycle path and the burst path so both behave identically.
module shift_reg_step
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  logic [2:0]       op,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_next
);

  always_comb begin
    q_next = q;
    case (op)
      MODE_HOLD: q_next = q;
      MODE_LOAD: q_next = d;
      MODE_SHL:  q_next = {q[WIDTH-2:0], sin_r};
      MODE_SHR:  q_next = {sin_l, q[WIDTH-1:1]};
      MODE_ROL:  q_next = {q[WIDTH-2:0], q[WIDTH-1]};
      MODE_ROR:  q_next = {q[0], q[WIDTH-1:1]};
      MODE_ASR:  q_next = {q[WIDTH-1], q[WIDTH-1:1]};
      MODE_CLR:  q_next = '0;
      default:   q_next = q;
    endcase
  end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal WIDTH-bit register: single-cycle ops under en, plus a burst mode that
// repeats one shift/rotate op shamt times with registered busy/done handshake.
module shift_reg_univ
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             start,
  input  logic [CNT_W-1:0] shamt,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [2:0]       step_op;
  logic [WIDTH-1:0] step_q;

  // While a burst runs the latched op drives the step unit; otherwise the live mode.
  assign step_op = (state_q == ST_RUN) ? op_q : mode;

  shift_reg_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .q      (q_q),
    .op     (step_op),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .d      (d),
    .q_next (step_q)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    op_d    = op_q;
    q_d     = q_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_RUN: begin
        q_d     = step_q;
        count_d = count_q - CNT_ONE;
        if (count_q == CNT_ONE) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          busy_d = 1'b1;
        end
      end
      default: begin
        // An accepted start owns this edge: q holds and en is ignored.
        if (start && is_shift_class(mode)) begin
          op_d    = mode;
          count_d = shamt;
          if (shamt == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end
        end else if (en) begin
          q_d = step_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rest) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      op_q    <= MODE_HOLD;
      q_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      op_q    <= op_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q      = q_q;
  assign sout_l = q_q[WIDTH-1];
  assign sout_r = q_q[0];
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_shift_reg_univ.sv
// Self-checking bench for shift_reg_univ: directed vector table, hand-written
// burst corner cases, then random stimulus against an arithmetic reference model.
module tb_shift_reg_univ;
  import shift_reg_pkg::*;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rest, en, start, sin_l, sin_r;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic [CNT_W-1:0] shamt;
  logic [WIDTH-1:0] q;
  logic             sout_l, sout_r, busy, done;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  shift_reg_univ #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk    (clk),
    .rest   (rest),
    .en     (en),
    .mode   (mode),
    .d      (d),
    .sin_l  (sin_l),
    .sin_r  (sin_r),
    .start  (start),
    .shamt  (shamt),
    .q      (q),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .busy   (busy),
    .done   (done)
  );

  typedef struct {
    logic       rst;
    logic       en;
    logic       start;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sl;
    logic       sr;
    logic [3:0] shamt;
    logic [7:0] eq;
    logic       eb;
    logic       ed;
  } vec_t;

  localparam int NVEC = 23;
  vec_t vecs [NVEC];

  function automatic vec_t mk(logic r, logic e, logic s, logic [2:0] m, logic [7:0] dv,
                              logic sl, logic sr, logic [3:0] sh,
                              logic [7:0] eq, logic eb, logic ed);
    vec_t v;
    v.rst = r; v.en = e; v.start = s; v.mode = m; v.d = dv; v.sl = sl; v.sr = sr;
    v.shamt = sh; v.eq = eq; v.eb = eb; v.ed = ed;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
    chk({tag, ".sout_l"}, 32'(sout_l), 32'(eq[7]));
    chk({tag, ".sout_r"}, 32'(sout_r), 32'(eq[0]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rest = 1'b0; en = 1'b0; start = 1'b0; mode = MODE_HOLD;
    d = '0; sin_l = 1'b0; sin_r = 1'b0; shamt = '0;
  endtask

  // Reference op computed with plain integer arithmetic on the register value.
  function automatic int model_op(int m, int qv, int dv, int sl, int sr);
    case (m)
      0: return qv;
      1: return dv;
      2: return (qv * 2) % 256 + sr;
      3: return qv / 2 + sl * 128;
      4: return (qv * 2) % 256 + qv / 128;
      5: return qv / 2 + (qv % 2) * 128;
      6: return qv / 2 + ((qv >= 128) ? 128 : 0);
      default: return 0;
    endcase
  endfunction

  initial begin
    idle_inputs();
    rest = 1'b1;

    //             rst  en  st  mode       d      sl sr sh   exp_q  b  dn
    vecs[0]  = mk(1, 0, 0, MODE_HOLD, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    vecs[1]  = mk(0, 1, 0, MODE_LOAD, 8'hA5, 0, 0, 0, 8'hA5, 0, 0);
    vecs[2]  = mk(1, 0, 0, MODE_HOLD, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    vecs[3]  = mk(0, 1, 0, MODE_LOAD, 8'h81, 0, 0, 0, 8'h81, 0, 0);
    vecs[4]  = mk(0, 1, 0, MODE_SHL,  8'h00, 0, 1, 0, 8'h03, 0, 0);
    vecs[5]  = mk(0, 1, 0, MODE_ROR,  8'h00, 0, 0, 0, 8'h81, 0, 0);
    vecs[6]  = mk(0, 1, 0, MODE_ASR,  8'h00, 0, 0, 0, 8'hC0, 0, 0);
    vecs[7]  = mk(0, 1, 0, MODE_CLR,  8'h00, 0, 0, 0, 8'h00, 0, 0);
    vecs[8]  = mk(0, 1, 0, MODE_LOAD, 8'h5A, 0, 0, 0, 8'h5A, 0, 0);
    vecs[9]  = mk(0, 1, 0, MODE_HOLD, 8'hFF, 0, 0, 0, 8'h5A, 0, 0);
    vecs[10] = mk(0, 0, 0, MODE_CLR,  8'hFF, 0, 0, 0, 8'h5A, 0, 0);
    vecs[11] = mk(0, 1, 0, MODE_SHR,  8'h00, 1, 0, 0, 8'hAD, 0, 0);
    vecs[12] = mk(0, 1, 0, MODE_ROL,  8'h00, 0, 0, 0, 8'h5B, 0, 0);
    vecs[13] = mk(0, 1, 0, MODE_LOAD, 8'h81, 0, 0, 0, 8'h81, 0, 0);
    // Burst ROL x3; en on the accept edge must be ignored.
    vecs[14] = mk(0, 1, 1, MODE_ROL,  8'h00, 0, 0, 3, 8'h81, 1, 0);
    vecs[15] = mk(0, 0, 0, MODE_HOLD, 8'h00, 0, 0, 0, 8'h03, 1, 0);
    vecs[16] = mk(0, 0, 0, MODE_HOLD, 8'h00, 0, 0, 0, 8'h06, 1, 0);
    vecs[17] = mk(0, 0, 0, MODE_HOLD, 8'h00, 0, 0, 0, 8'h0C, 0, 1);
    vecs[18] = mk(0, 0, 0, MODE_HOLD, 8'h00, 0, 0, 0, 8'h0C, 0, 0);
    // Zero-length burst, then a start with a non-shift mode.
    vecs[19] = mk(0, 0, 1, MODE_SHR,  8'h00, 1, 0, 0, 8'h0C, 0, 1);
    vecs[20] = mk(0, 0, 0, MODE_HOLD, 8'h00, 0, 0, 0, 8'h0C, 0, 0);
    vecs[21] = mk(0, 1, 1, MODE_LOAD, 8'h33, 0, 0, 5, 8'h33, 0, 0);
    vecs[22] = mk(0, 0, 0, MODE_HOLD, 8'h00, 0, 0, 0, 8'h33, 0, 0);

    for (int i = 0; i < NVEC; i++) begin
      rest = vecs[i].rst; en = vecs[i].en; start = vecs[i].start; mode = vecs[i].mode;
      d = vecs[i].d; sin_l = vecs[i].sl; sin_r = vecs[i].sr; shamt = vecs[i].shamt;
      tick();
      $display("[TB] vec %0d mode=%0d q=%02h busy=%0b done=%0b", i, vecs[i].mode, q, busy, done);
      check_out($sformatf("vec%0d", i), vecs[i].eq, vecs[i].eb, vecs[i].ed);
    end

    // Reset mid-burst aborts without a done pulse.
    idle_inputs(); en = 1'b1; mode = MODE_LOAD; d = 8'h01;
    tick(); check_out("abort_load", 8'h01, 0, 0);
    idle_inputs(); start = 1'b1; mode = MODE_SHL; shamt = 4'd4;
    tick(); check_out("abort_accept", 8'h01, 1, 0);
    idle_inputs();
    tick(); check_out("abort_shift1", 8'h02, 1, 0);
    rest = 1'b1;
    tick(); check_out("abort_reset", 8'h00, 0, 0);
    idle_inputs();
    for (int i = 0; i < 5; i++) begin
      tick(); check_out($sformatf("abort_after%0d", i), 8'h00, 0, 0);
    end
    $display("[TB] seq abort q=%02h busy=%0b done=%0b", q, busy, done);

    // Inputs ignored during RUN; back-to-back start in the done cycle.
    idle_inputs(); en = 1'b1; mode = MODE_LOAD; d = 8'h0F;
    tick(); check_out("ign_load", 8'h0F, 0, 0);
    idle_inputs(); start = 1'b1; mode = MODE_ROR; shamt = 4'd2;
    tick(); check_out("ign_accept", 8'h0F, 1, 0);
    start = 1'b1; en = 1'b1; mode = MODE_CLR; d = 8'hFF; shamt = 4'd7;
    tick(); check_out("ign_run1", 8'h87, 1, 0);
    tick(); check_out("ign_run2", 8'hC3, 0, 1);
    idle_inputs(); start = 1'b1; mode = MODE_SHL; shamt = 4'd1; sin_r = 1'b1;
    tick(); check_out("b2b_accept", 8'hC3, 1, 0);
    idle_inputs(); sin_r = 1'b1;
    tick(); check_out("b2b_shift", 8'h87, 0, 1);
    idle_inputs();
    tick(); check_out("b2b_idle", 8'h87, 0, 0);
    $display("[TB] seq ignore/back-to-back q=%02h busy=%0b done=%0b", q, busy, done);

    // Random stimulus against the reference model.
    begin
      int mq, remaining, bop, mdone;
      mq = 0; remaining = 0; bop = 0; mdone = 0;
      for (int c = 0; c < 400; c++) begin
        rest  = (c == 0) || ($urandom_range(0, 39) == 0);
        en    = $urandom_range(0, 1) == 1;
        start = $urandom_range(0, 4) == 0;
        mode  = 3'($urandom_range(0, 7));
        d     = 8'($urandom);
        sin_l = $urandom_range(0, 1) == 1;
        sin_r = $urandom_range(0, 1) == 1;
        shamt = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 3));
        if (rest) begin
          mq = 0; remaining = 0; mdone = 0;
        end else if (remaining > 0) begin
          mq = model_op(bop, mq, int'(d), int'(sin_l), int'(sin_r));
          remaining--;
          mdone = (remaining == 0) ? 1 : 0;
        end else if (start && int'(mode) >= 2 && int'(mode) <= 6) begin
          bop = int'(mode);
          remaining = int'(shamt);
          mdone = (shamt == 0) ? 1 : 0;
        end else begin
          mdone = 0;
          if (en) mq = model_op(int'(mode), mq, int'(d), int'(sin_l), int'(sin_r));
        end
        tick();
        $display("[TB] rnd %0d rst=%0b en=%0b st=%0b mode=%0d sh=%0d q=%02h busy=%0b done=%0b",
                 c, rest, en, start, mode, shamt, q, busy, done);
        check_out($sformatf("rnd%0d", c), 8'(mq), remaining > 0, mdone != 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal register for the sequential library: a WIDTH-bit register with parallel load, clear, hold, logical/arithmetic shift and rotate in both directions, plus a burst mode that applies one shift/rotate operation a programmed number of times with busy/done handshake. It is the general-purpose successor to the single-bit D flip-flop. It serves as a serialiser/deserialiser, a barrel-free multi-bit shifter, and a staging register in datapaths.

## Interface
Parameters:
- WIDTH, 8, register width (>= 2)
- CNT_W, 4, width of burst shift count (must hold WIDTH)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rest  in  1  reset, synchronous, active-high
- en  in  1  execute `mode` as a single-cycle op this edge
- mode  in  3  operation: 000 HOLD, 001 LOAD, 010 SHL, 011 SHR, 100 ROL, 101 ROR, 110 ASR, 111 CLR
- d  in  WIDTH  parallel load data
- sin_l  in  1  serial in, enters MSB on SHR
- sin_r  in  1  serial in, enters LSB on SHL
- start  in  1  request burst of `mode`, `shamt` steps
- shamt  in  CNT_W  burst step count
- q  out  WIDTH  register contents
- sout_l  out  1  q[WIDTH-1], combinational from q
- sout_r  out  1  q[0], combinational from q
- busy  out  1  burst in progress
- done  out  1  one-cycle pulse at burst completion

## Operation
- Op semantics on q: HOLD q; LOAD d; SHL {q[W-2:0],sin_r}; SHR {sin_l,q[W-1:1]}; ROL {q[W-2:0],q[W-1]}; ROR {q[0],q[W-1:1]}; ASR {q[W-1],q[W-1:1]}; CLR 0.
- Shift-class modes: 010–110. Only these are burst-capable.
- Priority per edge: rest > RUN state > accepted start > en > hold.
- FSM states: IDLE, RUN.
- IDLE, start=1, mode shift-class: latch op and count=shamt; q unchanged this edge; en ignored. If shamt=0: stay IDLE, done=1 next cycle. Else go RUN.
- IDLE, start=1, mode not shift-class: start ignored; en behaviour applies normally.
- RUN: each edge apply latched op (serial inputs sampled live each edge), count--. When count reaches 0 → IDLE, done=1 for exactly one cycle.
- In RUN, start, en, mode, shamt, d are ignored.
- rest: q=0, count=0, state IDLE, busy=0, done=0; a burst in flight is aborted with no done pulse.

## Timing
- Reset values: q=0, busy=0, done=0; sout_l=sout_r=0.
- Single op: q updated at the edge where en=1; visible next cycle.
- Burst shamt=N>=1 accepted at edge k: busy=1 during cycles after edges k..k+N-1; shifts at edges k+1..k+N; busy=0 and done=1 in the cycle after edge k+N; done drops after one cycle.
- Burst shamt=0: busy never rises; done=1 in the cycle after the accept edge.
- busy and done are registered; never both high.
- Back-to-back: new start is accepted in the same cycle done is high (state is IDLE).
- shamt > WIDTH is legal; it simply shifts/rotates that many times.

## Structure
- Package shift_reg_pkg: mode encodings as localparams/enum (MODE_HOLD … MODE_CLR), FSM state encoding, shift-class predicate function.
- Sub-module shift_reg_step: purely combinational next-value unit (q, op, sin_l, sin_r, d → q_next), shared by single-op and burst paths.
- Top: FSM, counter, op latch, q register, handshake flops.

## Test plan
(WIDTH=8)
- q=8'hA5, rest=1 one edge → q=8'h00, busy=0, done=0.
- en=1 LOAD d=8'h81 → q=8'h81; SHL sin_r=1 → 8'h03; ROR → 8'h81; ASR → 8'hC0; CLR → 8'h00; HOLD → unchanged.
- q=8'h81, start ROL shamt=3 → busy high 3 cycles, q 8'h03, 8'h06, 8'h0C, then done one cycle with busy=0, q=8'h0C.
- start SHR shamt=0 → no busy, done next cycle, q unchanged; start with mode=LOAD, en=1 → treated as plain LOAD, no done.
- Burst SHL shamt=4 from 8'h01 sin_r=0, rest after first shift → q=8'h00, busy=0, done never asserts.
- During RUN drive start=1, en=1, mode=CLR, d=8'hFF → ignored, burst completes with expected value; start asserted in done cycle → new burst accepted.
